// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RISC-V pipeline front end.
//   XLEN          default PC / instruction width
//   RESET_PC      default first fetch address
//   INST_NOP      canonical NOP encoding (addi x0, x0, 0)
//   fetch_entry_t one fetch-queue entry {pc, inst} at the default XLEN
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam logic [31:0]     INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Bundles the instruction-RAM read port, the redirect input and the decode
// valid/ready handshake of the fetch front end.
//   master : the fetch unit (drives imem_addr/imem_re and inst_*)
//   slave  : the environment (RAM, branch unit and decode)
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int XLEN = riscv_pkg::XLEN
);
  logic [XLEN-1:0] imem_addr;
  logic            imem_re;
  logic [XLEN-1:0] imem_dout;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_addr, imem_re, inst_valid, inst_data, inst_pc,
    input  imem_dout, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, imem_re, inst_valid, inst_data, inst_pc,
    output imem_dout, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous DEPTH-entry FIFO of fetch entries. Storage is register based,
// so the head is read directly from registers and holds steady while it is
// not popped. flush empties the queue and wins over a same-cycle push.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   push_i        write push_data_i at the tail
//   push_data_i   entry to write
//   pop_i         drop the head (ignored when empty)
//   flush_i       clear all entries
//   head_o        current head entry (all zeros after reset)
//   count_o       occupancy 0..DEPTH
//   overflow_o    push attempted into a full queue with no pop (design error)
// ---------------------------------------------------------------------------
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  entry_t                     push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, pop_ok, push_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);
  // A full queue can still take a push when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);

  assign overflow_o = push_i && full && !pop_ok && !flush_i;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (AW+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction-fetch front end: owns the PC, issues one-cycle-latency reads to
// the instruction RAM, buffers returned {pc, inst} pairs and hands them to
// decode over valid/ready. A redirect flushes everything and refetches.
// Ports:
//   clk_i             clock
//   rst_i             asynchronous active-high reset
//   bus_io            fetch_queue_if.master (imem read port, redirect, decode)
//   perf_redirects_o  redirect cycle count
//   perf_stalls_o     count of cycles with inst_valid low
// Optional feature: define FETCH_PERF_EN to build the performance counters;
// without it both perf outputs are tied to zero.
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fetch_queue_if.master        bus_io,
  output logic [31:0]          perf_redirects_o,
  output logic [31:0]          perf_stalls_o
);
  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q;
  logic            inflight_q;
  logic [CW-1:0]   occupancy;
  logic [CW:0]     credit_use;
  logic            pop, push, issue;
  entry_t          head, push_entry;

  // Head is hidden during a redirect so nothing stale transfers that cycle.
  assign bus_io.inst_valid = (occupancy != '0) && !bus_io.redirect_valid;
  assign pop               = bus_io.inst_valid && bus_io.inst_ready;

  // Credit check: queued entries plus the outstanding read, minus the entry
  // leaving this cycle, must leave room for the read issued now.
  assign credit_use = {1'b0, occupancy} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue      = !rst_i && !bus_io.redirect_valid
                      && (credit_use < (CW+1)'(DEPTH));

  assign bus_io.imem_re   = issue;
  assign bus_io.imem_addr = fetch_pc_q;

  // A response arriving during a redirect belongs to the old path.
  assign push = inflight_q && !bus_io.redirect_valid;

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = inflight_pc_q;
    push_entry.inst = bus_io.imem_dout;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus_io.redirect_valid) fetch_pc_d = {bus_io.redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)            fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .flush_i     (bus_io.redirect_valid),
    .head_o      (head),
    .count_o     (occupancy),
    .overflow_o  ()
  );

  assign bus_io.inst_data = head.inst;
  assign bus_io.inst_pc   = head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_redirects_q, perf_stalls_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_redirects_q <= '0;
      perf_stalls_q    <= '0;
    end else begin
      if (bus_io.redirect_valid) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (!bus_io.inst_valid)    perf_stalls_q    <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_redirects_o = perf_redirects_q;
  assign perf_stalls_o    = perf_stalls_q;
`else
  assign perf_redirects_o = '0;
  assign perf_stalls_o    = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0x100).
// A vector table covers reset release, streaming, back-to-back redirects and
// PC wrap; hand-written sequences cover back-pressure, redirect with a full
// pipe, asynchronous reset mid-stream and the perf counters.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic [31:0] perf_r, perf_s;
  int          errors = 0;
  int          checks = 0;
  logic        overflow_seen = 1'b0;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus_io           (bus),
    .perf_redirects_o (perf_r),
    .perf_stalls_o    (perf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Instruction RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_re === 1'b1) bus.imem_dout <= inst_of(bus.imem_addr);
  end

  // Any push into a full queue is a design error.
  always @(negedge clk) begin
    if (rst === 1'b0 && dut.u_fifo.overflow_o === 1'b1) overflow_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    tick();
    @(negedge clk);
    chk("rst inst_valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rst inst_data", bus.inst_data, 32'd0);
    chk("rst inst_pc", bus.inst_pc, 32'd0);
    chk("rst imem_re", {31'b0, bus.imem_re}, 32'd0);
    chk("rst imem_addr", bus.imem_addr, RST_PC);
    chk("rst perf_redirects", perf_r, 32'd0);
    chk("rst perf_stalls", perf_s, 32'd0);
    tick();
    rst = 1'b0;  // now in cycle 0
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        re;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  vec_t vt [16];

  int issues;
  logic [31:0] exp_r, exp_s;

  initial begin
    bus.imem_dout      = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    rst                = 1'b1;

    // rv, rpc, rdy | re, addr, vld, pc
    vt[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0};
    vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
    vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};
    vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0110, 1'b1, 32'h0000_0108};
    vt[5]  = '{1'b1, 32'h40,       1'b1, 1'b0, 32'h0000_0114, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 32'h80,       1'b1, 1'b0, 32'h0000_0040, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0084, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0088, 1'b1, 32'h0000_0080};
    vt[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_008C, 1'b1, 32'h0000_0084};
    vt[11] = '{1'b1, 32'hFFFF_FFFF,1'b1, 1'b0, 32'h0000_0090, 1'b0, 32'h0};
    vt[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vt[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    vt[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC};
    vt[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};

    // ---- table: reset release, stream, back-to-back redirect, PC wrap ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.redirect_valid = vt[i].rv;
      bus.redirect_pc    = vt[i].rpc;
      bus.inst_ready     = vt[i].rdy;
      @(negedge clk);
      $display("vec %0d: re=%0b addr=%h valid=%0b pc=%h data=%h", i,
               bus.imem_re, bus.imem_addr, bus.inst_valid, bus.inst_pc, bus.inst_data);
      chk($sformatf("vec%0d imem_re", i), {31'b0, bus.imem_re}, {31'b0, vt[i].re});
      chk($sformatf("vec%0d imem_addr", i), bus.imem_addr, vt[i].addr);
      chk($sformatf("vec%0d inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, vt[i].vld});
      if (vt[i].vld) begin
        chk($sformatf("vec%0d inst_pc", i), bus.inst_pc, vt[i].pc);
        chk($sformatf("vec%0d inst_data", i), bus.inst_data, inst_of(vt[i].pc));
      end
      tick();
    end
    bus.redirect_valid = 1'b0;

    // ---- back-pressure: ready low from cycle 0 ----
    bus.inst_ready = 1'b0;
    do_reset();
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.imem_re === 1'b1) issues++;
      if (c >= 2) begin
        $display("bp cycle %0d: valid=%0b pc=%h", c, bus.inst_valid, bus.inst_pc);
        chk($sformatf("bp c%0d valid", c), {31'b0, bus.inst_valid}, 32'd1);
        chk($sformatf("bp c%0d head pc", c), bus.inst_pc, RST_PC);
        chk($sformatf("bp c%0d head data", c), bus.inst_data, inst_of(RST_PC));
      end
      tick();
    end
    chk("bp issue count", issues, 32'd4);
    chk("bp occupancy", 32'(dut.u_fifo.count_o), 32'd4);
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("drain %0d: valid=%0b pc=%h", k, bus.inst_valid, bus.inst_pc);
      chk($sformatf("drain%0d valid", k), {31'b0, bus.inst_valid}, 32'd1);
      chk($sformatf("drain%0d pc", k), bus.inst_pc, RST_PC + 32'(4 * k));
      chk($sformatf("drain%0d data", k), bus.inst_data, inst_of(RST_PC + 32'(4 * k)));
      tick();
    end

    // ---- asynchronous reset mid-stream ----
    rst = 1'b1;
    #1;
    $display("async reset: valid=%0b re=%0b addr=%h", bus.inst_valid, bus.imem_re, bus.imem_addr);
    chk("async rst valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("async rst imem_re", {31'b0, bus.imem_re}, 32'd0);
    chk("async rst imem_addr", bus.imem_addr, RST_PC);
    chk("async rst inst_pc", bus.inst_pc, 32'd0);

    // ---- redirect with 3 queued entries and one read in flight ----
    bus.inst_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) tick();
    chk("rd pre occupancy", 32'(dut.u_fifo.count_o), 32'd3);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2002;
    @(negedge clk);
    $display("redirect cycle: valid=%0b re=%0b", bus.inst_valid, bus.imem_re);
    chk("rd N valid", {31'b0, bus.inst_valid}, 32'd0);
    chk("rd N imem_re", {31'b0, bus.imem_re}, 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd N+1 imem_re", {31'b0, bus.imem_re}, 32'd1);
    chk("rd N+1 imem_addr", bus.imem_addr, 32'h0000_2000);
    chk("rd N+1 valid", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("rd N+2 valid", {31'b0, bus.inst_valid}, 32'd0);
    tick();
    @(negedge clk);
    $display("redirect N+3: valid=%0b pc=%h", bus.inst_valid, bus.inst_pc);
    chk("rd N+3 valid", {31'b0, bus.inst_valid}, 32'd1);
    chk("rd N+3 pc", bus.inst_pc, 32'h0000_2000);
    chk("rd N+3 data", bus.inst_data, inst_of(32'h0000_2000));
    tick();
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("rd N+4 pc", bus.inst_pc, 32'h0000_2000);
    tick();
    @(negedge clk);
    chk("rd N+5 pc", bus.inst_pc, 32'h0000_2004);
    tick();

    // ---- perf counters: 5 redirects, 9 empty cycles up to the sample ----
    bus.inst_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      bus.redirect_valid = (c >= 5 && c <= 9);
      bus.redirect_pc    = 32'h0000_0300 + 32'(c * 16);
      tick();
    end
    bus.redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    exp_r = 32'd5;
    exp_s = 32'd9;
`else
    exp_r = 32'd0;
    exp_s = 32'd0;
`endif
    $display("perf: redirects=%0d stalls=%0d", perf_r, perf_s);
    chk("perf_redirects", perf_r, exp_r);
    chk("perf_stalls", perf_s, exp_s);
    chk("perf valid resumed", {31'b0, bus.inst_valid}, 32'd1);

    chk("no queue overflow", {31'b0, overflow_seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the RISC-V pipeline. It owns the program counter, issues reads to the instruction block RAM, and buffers returned instructions with their PCs in a small queue. It presents them to decode over a valid/ready handshake and handles redirects from branches and jumps with a full flush. It replaces the bare PC register and PC mux in the datapath, so decode can stall without re-fetching.

## Interface
Parameters:
- XLEN, 32: PC and instruction width.
- DEPTH, 4: queue entries. Must be a power of two and at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- Clock  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- imem_addr  out  XLEN  instruction RAM read address; bits [1:0] are always 0.
- imem_re  out  1  read enable; data returns on imem_dout in the next cycle.
- imem_dout  in  XLEN  instruction RAM read data, valid one cycle after imem_re.
- redirect_valid  in  1  branch or jump taken; flush and refetch.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and treated as 0.
- inst_valid  out  1  queue head is valid.
- inst_data  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of the head instruction.
- inst_ready  in  1  decode accepts the head.
- perf_redirects  out  32  redirect count; only active with FETCH_PERF_EN.
- perf_stalls  out  32  count of cycles with inst_valid=0; only active with FETCH_PERF_EN.

## Operation
- State:
  - fetch_pc (XLEN bits).
  - inflight flag (one outstanding RAM read at most per cycle).
  - queue of {pc, inst} entries.
  - occupancy counter, 0..DEPTH.
- Issue rule:
  - imem_re = !Reset && !redirect_valid && (occupancy + inflight − pop) < DEPTH, where pop = inst_valid && inst_ready.
  - On issue, imem_addr = fetch_pc and fetch_pc advances by 4, wrapping modulo 2^XLEN.
- Return: inflight is set by the issue cycle. In the next cycle, {pc of that read, imem_dout} is pushed unless a redirect occurs in that cycle.
- Credits guarantee the queue never overflows. A push into a full queue is a design error and the bench must flag it.
- Simultaneous push and pop: occupancy is unchanged, and a queue that started empty with ready=1 streams at 1 instruction per cycle.
- Pop from empty: cannot happen, because inst_valid=0.
- Redirect (highest priority):
  - fetch_pc ← {redirect_pc[XLEN−1:2], 2'b00}.
  - Queue cleared and occupancy set to 0.
  - The in-flight response is discarded.
  - No issue in that cycle.
  - inst_valid is forced to 0 combinationally, so no transfer occurs in that cycle.
- Back-to-back redirects: the last one wins, and fetch resumes the cycle after the final redirect.
- Reset: fetch_pc=RESET_PC, occupancy=0, inflight=0, counters=0.
- Outputs during reset:
  - inst_valid=0, inst_data=0, inst_pc=0.
  - imem_re=0, imem_addr=RESET_PC.
  - Reset asserted mid-stream drops everything asynchronously.

## Timing
- Cycle 0 (first cycle with Reset low): imem_re=1, imem_addr=RESET_PC.
- Cycle 1: data arrives and is pushed at the end of the cycle.
- Cycle 2: inst_valid=1, inst_pc=RESET_PC. Fetch-to-decode latency is 2 cycles.
- Redirect in cycle N: issue at the target in N+1, inst_valid for the target in N+3.
- With inst_ready held at 1: sustained throughput of 1 instruction per cycle.
- With inst_ready held at 0: issue stops once occupancy + inflight = DEPTH, and the head stays stable. inst_data and inst_pc must not change while inst_valid && !inst_ready.
- inst_data and inst_pc come straight from registers/queue storage. The only combinational input-to-output paths are:
  - redirect_valid → inst_valid.
  - redirect_valid and inst_ready → imem_re.

## Configuration
- FETCH_PERF_EN defined:
  - perf_redirects increments on every cycle with redirect_valid=1.
  - perf_stalls increments on every cycle with inst_valid=0 and Reset=0.
  - Both are 32-bit, wrap on overflow, and clear on Reset.
- FETCH_PERF_EN undefined: both ports are tied to 0, no counter logic is built, and all other behaviour is identical.

## Structure
- Shared package riscv_pkg holds:
  - XLEN, RESET_PC default, INST_NOP (32'h0000_0013).
  - The fetch entry type {pc, inst}.
- One sub-module, fetch_fifo: a synchronous DEPTH-entry FIFO of entries with push, pop, flush, occupancy, and a registered head. flush takes priority over push.
- PC logic, credit check, inflight tracking and perf counters sit in fetch_queue.

## Test plan
- Reset release with RESET_PC=0x100 and ready=1 → imem_addr 0x100, 0x104, 0x108 on cycles 0, 1, 2; inst_pc 0x100 on cycle 2, then +4 every cycle.
- ready=0 from cycle 0 with DEPTH=4 → exactly 4 issues, occupancy 4, and the head stays at 0x100 stable. After releasing ready, the 4 entries drain in order with no gap.
- Redirect to 0x2002 while the queue holds 3 entries and one read is in flight → inst_valid=0 that cycle, the stale data is never presented, next imem_addr=0x2000, inst_pc=0x2000 three cycles later.
- Redirects on two consecutive cycles to 0x40 then 0x80 → only 0x80 is fetched and 0x40 never appears.
- fetch_pc=0xFFFF_FFFC with XLEN=32 → next issue address 0x0000_0000, and inst_pc wraps the same way.
- With FETCH_PERF_EN: 5 redirects plus a 10-cycle ready=0-free empty window → perf_redirects=5 and perf_stalls counts every empty cycle. Without the macro, both read 0.
